// File: rtl/apb_master_bridge_if.sv
// Command/response and APB3 signal bundle for apb_master_bridge.
// master = bridge side, slave = command source plus APB slaves.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic [DATA_W-1:0] PRDATA2;
    logic              PREADY1;
    logic              PREADY2;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA1, PRDATA2, PREADY1, PREADY2,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA1, PRDATA2, PREADY1, PREADY2,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-beat command port to APB3 requester with two-slave decode
// and a wait-state timeout that aborts transfers to a hung slave.
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int SEL_BIT = 7,
    parameter int TIMEOUT = 16
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t state_q;
    state_t state_d;

    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_q;
    logic [7:0]        wait_q;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              accept;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              done;
    logic              abort;

    logic cmd_ready_c;
    logic psel1_c;
    logic psel2_c;
    logic penable_c;

    // Only the addressed slave's handshake is ever looked at.
    assign sel_ready = sel_q ? bus.PREADY2 : bus.PREADY1;
    assign sel_rdata = sel_q ? bus.PRDATA2 : bus.PRDATA1;

    assign accept = (state_q == IDLE) && bus.cmd_valid;
    assign done   = (state_q == ACCESS) && sel_ready;
    // PREADY wins over the timeout when both land in the same cycle.
    assign abort  = (state_q == ACCESS) && !sel_ready &&
                    ((wait_q + 8'd1) == TO_CNT);

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and APB control decode from the current state.
    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        psel1_c     = 1'b0;
        psel2_c     = 1'b0;
        penable_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                psel1_c = !sel_q;
                psel2_c = sel_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel1_c   = !sel_q;
                psel2_c   = sel_q;
                penable_c = 1'b1;
                if (done || abort) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture; these registers also drive PADDR/PWDATA/PWRITE
    // so the bus holds the last transfer's values while idle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
        end else if (accept) begin
            write_q <= bus.cmd_write;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            sel_q   <= bus.cmd_addr[SEL_BIT];
        end
    end

    // Wait-state counter: cleared on entry to SETUP, counts ACCESS
    // cycles in which the selected slave holds PREADY low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else if (accept) begin
            wait_q <= '0;
        end else if ((state_q == ACCESS) && !sel_ready) begin
            wait_q <= wait_q + 8'd1;
        end
    end

    // One-cycle response in the first IDLE cycle after a transfer;
    // data and error are forced to zero outside that pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done || abort;
            rsp_err_q   <= abort;
            rsp_rdata_q <= (done && !write_q) ? sel_rdata : '0;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.PSEL1     = psel1_c;
    assign bus.PSEL2     = psel2_c;
    assign bus.PENABLE   = penable_c;
    assign bus.PWRITE    = write_q;
    assign bus.PADDR     = addr_q;
    assign bus.PWDATA    = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: memory-backed APB slaves
// with programmable wait states and a transaction-level reference.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic PCLK = 1'b0;
    logic PRESETn;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .SEL_BIT(7),
        .TIMEOUT(TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       err;
        int         psel_n;
    } exp_t;

    exp_t expq[$];

    int         cyc = 0;
    int         cur_wait = 0;
    logic       cur_write = 1'b0;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] cur_wdata = 8'h00;

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [7:0] ref1 [256];
    logic [7:0] ref2 [256];

    int   acc_cnt = 0;
    logic noise = 1'b0;
    int   psel_n = 0;
    logic [7:0] hold_addr = 8'h00;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave side: unselected PREADY is noise, selected PREADY rises
    // after cur_wait low ACCESS cycles.
    assign bus.PREADY1 = bus.PSEL1 ? (bus.PENABLE && acc_cnt == cur_wait) : noise;
    assign bus.PREADY2 = bus.PSEL2 ? (bus.PENABLE && acc_cnt == cur_wait) : noise;
    assign bus.PRDATA1 = mem1[bus.PADDR];
    assign bus.PRDATA2 = mem2[bus.PADDR];

    always @(posedge PCLK) begin
        noise <= 1'($urandom);
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'(i) ^ 8'h5A;
                mem2[i] <= ~8'(i);
            end
        end
        if (bus.PENABLE && !(bus.PSEL1 ? bus.PREADY1 : bus.PREADY2))
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
        if (bus.PSEL1 && bus.PENABLE && bus.PREADY1 && bus.PWRITE)
            mem1[bus.PADDR] <= bus.PWDATA;
        if (bus.PSEL2 && bus.PENABLE && bus.PREADY2 && bus.PWRITE)
            mem2[bus.PADDR] <= bus.PWDATA;
    end

    // Bus and response monitor.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            psel_n    <= 0;
            hold_addr <= 8'h00;
        end else begin
            chk("psel_onehot", 32'(bus.PSEL1 & bus.PSEL2), 0);
            if (bus.PSEL1 || bus.PSEL2) begin
                psel_n    <= psel_n + 1;
                hold_addr <= cur_addr;
                chk("psel_dec", 32'({bus.PSEL2, bus.PSEL1}), cur_addr[7] ? 2 : 1);
                chk("paddr", 32'(bus.PADDR), 32'(cur_addr));
                chk("pwrite", 32'(bus.PWRITE), 32'(cur_write));
                if (cur_write) chk("pwdata", 32'(bus.PWDATA), 32'(cur_wdata));
                chk("ready_busy", 32'(bus.cmd_ready), 0);
            end else begin
                chk("penable_idle", 32'(bus.PENABLE), 0);
                chk("ready_idle", 32'(bus.cmd_ready), 1);
                chk("paddr_hold", 32'(bus.PADDR), 32'(hold_addr));
            end
            if (bus.rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("rsp_spurious", 1, 0);
                end else begin
                    chk("rsp_cyc", 32'(cyc), 32'(expq[0].cyc));
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(expq[0].rdata));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(expq[0].err));
                    chk("psel_len", 32'(psel_n), 32'(expq[0].psel_n));
                    void'(expq.pop_front());
                end
                psel_n <= 0;
            end else begin
                chk("rdata_quiet", 32'(bus.rsp_rdata), 0);
                chk("err_quiet", 32'(bus.rsp_err), 0);
            end
        end
    end

    // Present one command at a negedge and wait until it is taken.
    // busy_noise keeps cmd_valid high with junk while the bridge is busy.
    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input int wt,
                         input bit busy_noise);
        int   n;
        bit   ok;
        exp_t e;
        n = 0;
        while (!bus.cmd_ready) begin
            if (busy_noise) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'($urandom);
                bus.cmd_addr  = 8'($urandom);
                bus.cmd_wdata = 8'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge PCLK);
            n++;
            if (n > 400) begin
                chk("ready_timeout", 0, 1);
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        ok       = (wt < TO);
        e.cyc    = ok ? cyc + 3 + wt : cyc + 2 + TO;
        e.err    = !ok;
        e.psel_n = ok ? 2 + wt : 1 + TO;
        e.rdata  = 8'h00;
        if (ok && !w) e.rdata = a[7] ? ref2[a] : ref1[a];
        if (ok && w) begin
            if (a[7]) ref2[a] = d;
            else      ref1[a] = d;
        end
        cur_wait  = wt;
        cur_addr  = a;
        cur_write = w;
        cur_wdata = d;
        expq.push_back(e);
        @(negedge PCLK);
        if (!busy_noise) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.cmd_valid = 1'b0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain", 32'(expq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref1[i] = 8'(i) ^ 8'h5A;
            ref2[i] = ~8'(i);
        end
        #2;
        chk("rst_psel1", 32'(bus.PSEL1), 0);
        chk("rst_psel2", 32'(bus.PSEL2), 0);
        chk("rst_penable", 32'(bus.PENABLE), 0);
        chk("rst_paddr", 32'(bus.PADDR), 0);
        chk("rst_pwdata", 32'(bus.PWDATA), 0);
        chk("rst_pwrite", 32'(bus.PWRITE), 0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        issue(1'b1, 8'h05, 8'hA5, 0, 1'b0);
        issue(1'b0, 8'h05, 8'h00, 0, 1'b0);
        issue(1'b1, 8'h85, 8'h3C, 0, 1'b0);
        issue(1'b0, 8'h85, 8'h00, 0, 1'b0);
        issue(1'b0, 8'h05, 8'h00, 0, 1'b0);
        issue(1'b0, 8'h90, 8'h00, 3, 1'b0);
        issue(1'b1, 8'h91, 8'h77, 3, 1'b0);
        issue(1'b0, 8'h10, 8'h00, 255, 1'b0);
        issue(1'b1, 8'h11, 8'h44, TO, 1'b0);
        issue(1'b0, 8'h11, 8'h00, TO - 1, 1'b0);
        issue(1'b0, 8'h05, 8'h00, 0, 1'b0);
        drain();

        for (int k = 0; k < 80; k++) begin
            bit busy;
            busy = 1'($urandom);
            issue(1'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 6)), busy);
            if (!busy) repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        drain();

        issue(1'b0, 8'h20, 8'h00, 255, 1'b0);
        @(negedge PCLK);
        @(negedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_psel", 32'({bus.PSEL1, bus.PSEL2}), 0);
        chk("mid_penable", 32'(bus.PENABLE), 0);
        chk("mid_paddr", 32'(bus.PADDR), 0);
        chk("mid_pwdata", 32'(bus.PWDATA), 0);
        chk("mid_pwrite", 32'(bus.PWRITE), 0);
        chk("mid_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
        chk("mid_ready", 32'(bus.cmd_ready), 1);
        expq.delete();
        @(negedge PCLK);
        @(posedge PCLK);
        #2;
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", 32'(bus.cmd_ready), 1);
        repeat (10) @(negedge PCLK);
        issue(1'b0, 8'h05, 8'h00, 1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
